// File: rtl/uart_tx_arbiter.sv
// Purpose: share one uart_tx between two byte channels, each buffered by a small FIFO.
// Latency: 2 cycles from chN_valid to tx_en when idle (1 cycle FIFO write, 1 cycle grant).
// Backpressure: tx_rdy stalls grants; a full FIFO drops the incoming byte and bumps its saturating drop counter.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   ch0_valid/ch0_data         channel 0 byte strobe (forwarded board traffic)
//   ch1_valid/ch1_data         channel 1 byte strobe (PC injection)
//   prio_mode                  0 = round-robin, 1 = strict priority to ch1
//   ch0_enable                 0 = ch0 pushes ignored (not counted as drops)
//   tx_rdy                     uart_tx idle indication
//   tx_en/tx_data/tx_src       start strobe, byte and source channel towards uart_tx
//   ch0_level/ch1_level        FIFO occupancy, 0..depth
//   ch0_drops/ch1_drops        saturating overflow counters

module uart_tx_arb_fifo #(
  parameter int DATA_W = 8,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [AW:0]       level,
  output logic              empty
);
  // Purpose: small show-ahead FIFO, head visible on rdata while non-empty.
  // Latency: a pushed byte is visible on rdata the cycle after the push.
  // Backpressure: push while full and pop while empty are ignored.

  localparam int          DEPTH_N = 1 << AW;
  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH_N];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo depth on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module uart_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ch0_valid,
  input  logic [DATA_W-1:0]  ch0_data,
  input  logic               ch1_valid,
  input  logic [DATA_W-1:0]  ch1_data,
  input  logic               prio_mode,
  input  logic               ch0_enable,
  input  logic               tx_rdy,
  output logic               tx_en,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_src,
  output logic [FIFO_AW:0]   ch0_level,
  output logic [FIFO_AW:0]   ch1_level,
  output logic [CNT_W-1:0]   ch0_drops,
  output logic [CNT_W-1:0]   ch1_drops
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  state_t            state;
  logic              rr_ptr;       // channel favoured when both FIFOs hold data
  logic              busy_wait;    // one WAIT_BUSY cycle already spent with tx_rdy high
  logic              ch0_req;
  logic              ch1_req;
  logic              ch0_empty;
  logic              ch1_empty;
  logic [DATA_W-1:0] ch0_head;
  logic [DATA_W-1:0] ch1_head;
  logic              sel_ch1;
  logic              start;
  logic              pop0;
  logic              pop1;

  // Disabled ch0 traffic is filtered before the FIFO, so it never reaches the drop counter.
  assign ch0_req = ch0_valid && ch0_enable;
  assign ch1_req = ch1_valid;

  uart_tx_arb_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (ch0_req),
    .wdata (ch0_data),
    .pop   (pop0),
    .rdata (ch0_head),
    .level (ch0_level),
    .empty (ch0_empty)
  );

  uart_tx_arb_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (ch1_req),
    .wdata (ch1_data),
    .pop   (pop1),
    .rdata (ch1_head),
    .level (ch1_level),
    .empty (ch1_empty)
  );

  // Full check uses the pre-edge level, so a push racing a pop on a full FIFO is still a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch0_drops <= '0;
      ch1_drops <= '0;
    end else begin
      if (ch0_req && (ch0_level == DEPTH) && (ch0_drops != '1))
        ch0_drops <= ch0_drops + CNT_W'(1);
      if (ch1_req && (ch1_level == DEPTH) && (ch1_drops != '1))
        ch1_drops <= ch1_drops + CNT_W'(1);
    end
  end

  // A lone non-empty channel wins regardless of mode or pointer.
  always_comb begin
    sel_ch1 = 1'b0;
    if (prio_mode)      sel_ch1 = !ch1_empty;
    else if (ch0_empty) sel_ch1 = 1'b1;
    else if (ch1_empty) sel_ch1 = 1'b0;
    else                sel_ch1 = rr_ptr;
  end

  assign start = (state == IDLE) && tx_rdy && !(ch0_empty && ch1_empty);
  assign pop0  = start && !sel_ch1;
  assign pop1  = start && sel_ch1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      tx_src    <= 1'b0;
      rr_ptr    <= 1'b0;
      busy_wait <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_data   <= sel_ch1 ? ch1_head : ch0_head;
            tx_src    <= sel_ch1;
            tx_en     <= 1'b1;
            rr_ptr    <= !sel_ch1;
            busy_wait <= 1'b0;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // uart_tx only reacts one cycle after tx_en, so allow two samples
          // before giving up on the byte.
          if (!tx_rdy)        state     <= WAIT_DONE;
          else if (busy_wait) state     <= IDLE;
          else                busy_wait <= 1'b1;
        end
        WAIT_DONE: begin
          if (tx_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch0_valid = 1'b0;
  logic [7:0] ch0_data = 8'h00;
  logic       ch1_valid = 1'b0;
  logic [7:0] ch1_data = 8'h00;
  logic       prio_mode = 1'b0;
  logic       ch0_enable = 1'b1;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_src;
  logic [2:0] ch0_level;
  logic [2:0] ch1_level;
  logic [7:0] ch0_drops;
  logic [7:0] ch1_drops;

  int n_tests = 0;
  int n_fail  = 0;
  int en_count = 0;

  // Simple uart_tx model: goes busy the cycle after tx_en for a few cycles.
  logic hold_busy = 1'b0;
  int   busy_cnt  = 0;
  assign tx_rdy = (busy_cnt == 0) && !hold_busy;

  logic [8:0] sb[$];   // {src, data} in expected emission order

  uart_tx_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ch0_valid  (ch0_valid),
    .ch0_data   (ch0_data),
    .ch1_valid  (ch1_valid),
    .ch1_data   (ch1_data),
    .prio_mode  (prio_mode),
    .ch0_enable (ch0_enable),
    .tx_rdy     (tx_rdy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_src     (tx_src),
    .ch0_level  (ch0_level),
    .ch1_level  (ch1_level),
    .ch0_drops  (ch0_drops),
    .ch1_drops  (ch1_drops)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_en)              busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every tx_en must match the head of the scoreboard.
  always @(negedge clk) begin
    if (tx_en) begin
      en_count++;
      if (sb.size() == 0) begin
        chk("tx_en_unexpected", int'(tx_en), 0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("emit_src_data", int'({tx_src, tx_data}), int'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("tx_en_in_rst", int'(tx_en), 0);
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic ch, input logic [7:0] d);
    if (ch) begin ch1_valid = 1'b1; ch1_data = d; end
    else    begin ch0_valid = 1'b1; ch0_data = d; end
    step();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  task automatic push2(input logic [7:0] d0, input logic [7:0] d1);
    ch0_valid = 1'b1; ch0_data = d0;
    ch1_valid = 1'b1; ch1_data = d1;
    step();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  task automatic sb_add(input logic src, input logic [7:0] d);
    sb.push_back({src, d});
  endtask

  // Wait until the scoreboard is empty and the transmitter has been idle a few cycles.
  task automatic drain(input string tag);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 1000) begin
      step();
      cyc++;
      if (sb.size() == 0 && tx_rdy && !tx_en) quiet++;
      else quiet = 0;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int en_snap;
    logic [7:0] d;

    // Reset state
    step();
    do_reset();
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_src", int'(tx_src), 0);
    chk("rst_ch0_level", int'(ch0_level), 0);
    chk("rst_ch1_level", int'(ch1_level), 0);
    chk("rst_ch0_drops", int'(ch0_drops), 0);
    chk("rst_ch1_drops", int'(ch1_drops), 0);
    step();

    // Single byte: tx_en exactly two cycles after the valid strobe
    sb_add(1'b0, 8'h41);
    push(1'b0, 8'h41);
    chk("single_lvl_c1", int'(ch0_level), 1);
    chk("single_en_c1", int'(tx_en), 0);
    step();
    chk("single_en_c2", int'(tx_en), 1);
    chk("single_data", int'(tx_data), 'h41);
    chk("single_src", int'(tx_src), 0);
    chk("single_lvl_c2", int'(ch0_level), 0);
    drain("single_drain");

    // Burst while busy, then in-order release
    hold_busy = 1'b1;
    en_snap = en_count;
    for (int i = 1; i <= 4; i++) begin
      sb_add(1'b0, 8'(i));
      push(1'b0, 8'(i));
    end
    step();
    chk("burst_level", int'(ch0_level), 4);
    chk("burst_no_en", en_count - en_snap, 0);
    hold_busy = 1'b0;
    drain("burst_drain");

    // Overflow: 6 pushes into depth 4, then saturate the counter
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 8'h10 + 8'(i);
      if (i < 4) sb_add(1'b0, d);
      push(1'b0, d);
    end
    chk("ovf_drops", int'(ch0_drops), 2);
    chk("ovf_level", int'(ch0_level), 4);
    for (int i = 0; i < 298; i++) push(1'b0, 8'hEE);
    chk("ovf_sat", int'(ch0_drops), 255);
    chk("ovf_level_sat", int'(ch0_level), 4);
    chk("ovf_ch1_drops", int'(ch1_drops), 0);
    hold_busy = 1'b0;
    drain("ovf_drain");

    // Round-robin from a fresh pointer
    do_reset();
    hold_busy = 1'b1;
    prio_mode = 1'b0;
    sb_add(1'b0, 8'hA0); sb_add(1'b1, 8'hB0);
    sb_add(1'b0, 8'hA1); sb_add(1'b1, 8'hB1);
    push2(8'hA0, 8'hB0);
    push2(8'hA1, 8'hB1);
    chk("rr_lvl0", int'(ch0_level), 2);
    chk("rr_lvl1", int'(ch1_level), 2);
    hold_busy = 1'b0;
    drain("rr_drain");

    // Strict priority to ch1
    hold_busy = 1'b1;
    prio_mode = 1'b1;
    sb_add(1'b1, 8'hB0); sb_add(1'b1, 8'hB1);
    sb_add(1'b0, 8'hA0); sb_add(1'b0, 8'hA1);
    push2(8'hA0, 8'hB0);
    push2(8'hA1, 8'hB1);
    hold_busy = 1'b0;
    drain("prio_drain");
    prio_mode = 1'b0;

    // ch0 disabled: pushes vanish without counting
    hold_busy = 1'b1;
    ch0_enable = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b0, 8'h55);
    chk("dis_level", int'(ch0_level), 0);
    chk("dis_drops", int'(ch0_drops), 0);
    ch0_enable = 1'b1;
    hold_busy = 1'b0;
    drain("dis_drain");

    // Reset in WAIT_DONE with three bytes still queued
    sb_add(1'b0, 8'hC0);
    push(1'b0, 8'hC0);
    push(1'b0, 8'hC1);
    push(1'b0, 8'hC2);
    push(1'b0, 8'hC3);
    chk("midrst_pre_level", int'(ch0_level), 3);
    chk("midrst_busy", int'(tx_rdy), 0);
    rst = 1'b1;
    step();
    chk("midrst_tx_en", int'(tx_en), 0);
    chk("midrst_level", int'(ch0_level), 0);
    rst = 1'b0;
    en_snap = en_count;
    repeat (40) step();
    chk("midrst_no_emit", en_count - en_snap, 0);
    chk("midrst_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
